// File: rtl/tcp_mem_sched.sv
// Ring scheduler for the TCP write-memory buffers: orders generator fills
// around the ring and hands buffers to the TX controller. Retransmissions
// go first, then fresh segments in write order.
module tcp_mem_sched #(
  parameter int N_BUF = 2,
  localparam int IW = $clog2(N_BUF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BUF-1:0] buf_wr_lock_i,
  input  logic [N_BUF-1:0] buf_rd_lock_i,
  input  logic [N_BUF-1:0] buf_seq_lock_i,
  input  logic             controller_work_st_i,
  input  logic             gen_wr_req_i,
  input  logic             gen_wr_stop_i,
  output logic             gen_wr_gnt_o,
  output logic [N_BUF-1:0] wr_sel_o,
  input  logic             tx_req_i,
  input  logic             tx_stop_i,
  output logic             tx_gnt_o,
  output logic             tx_start_o,
  output logic             tx_retx_o,
  output logic [N_BUF-1:0] rd_sel_o,
  output logic [IW-1:0]    tx_idx_o
);

  localparam int CW = $clog2(N_BUF + 1);

  typedef enum logic {W_IDLE, W_BUSY} wr_state_e;
  typedef enum logic {R_IDLE, R_BUSY} rd_state_e;

  wr_state_e        wr_st_q;
  rd_state_e        rd_st_q;
  logic [IW-1:0]    wr_ptr_q;
  logic [CW-1:0]    occ_q;
  logic [CW-1:0]    sent_q;
  logic [N_BUF-1:0] prev_wr_lock_q;

  logic [IW-1:0]    old_ptr, new_ptr, retx_idx, rd_idx_d;
  logic [N_BUF-1:0] fall;
  int               n_fall;
  logic             retx_hit, fresh_hit, rd_go, fresh_go, wr_done;

  function automatic logic [IW-1:0] ring_idx(input int v);
    int m;
    m = v % N_BUF;
    return IW'(m);
  endfunction

  function automatic logic [N_BUF-1:0] onehot(input logic [IW-1:0] i);
    logic [N_BUF-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic int popcount(input logic [N_BUF-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < N_BUF; i++) c += int'(v[i]);
    return c;
  endfunction

  // Counter update clamped to 0..N_BUF so a stray lock fall cannot wrap it.
  function automatic logic [CW-1:0] count_next(input logic [CW-1:0] c, input logic inc,
                                               input int dec);
    int v;
    v = int'(c) + int'(inc) - dec;
    if (v < 0) v = 0;
    if (v > N_BUF) v = N_BUF;
    return CW'(v);
  endfunction

  // Ring pointers, released buffers and read-candidate selection.
  always_comb begin
    logic [IW-1:0] b;
    old_ptr   = ring_idx(int'(wr_ptr_q) + N_BUF - int'(occ_q));
    new_ptr   = ring_idx(int'(old_ptr) + int'(sent_q));
    fall      = prev_wr_lock_q & ~buf_wr_lock_i;
    n_fall    = popcount(fall);
    retx_hit  = 1'b0;
    retx_idx  = '0;
    b         = '0;
    for (int k = 0; k < N_BUF; k++) begin
      b = ring_idx(int'(old_ptr) + k);
      if (!retx_hit && (k < int'(sent_q)) && buf_wr_lock_i[b] && !buf_rd_lock_i[b] &&
          buf_seq_lock_i[b]) begin
        retx_hit = 1'b1;
        retx_idx = b;
      end
    end
    fresh_hit = (sent_q < occ_q) && buf_wr_lock_i[new_ptr];
    rd_go     = controller_work_st_i && tx_req_i && (rd_st_q == R_IDLE) &&
                (retx_hit || fresh_hit);
    fresh_go  = rd_go && !retx_hit;
    rd_idx_d  = retx_hit ? retx_idx : new_ptr;
    wr_done   = (wr_st_q == W_BUSY) && gen_wr_stop_i;
  end

  // Write FSM: grant the buffer at wr_ptr, advance the ring when the fill ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_st_q      <= W_IDLE;
      wr_ptr_q     <= '0;
      gen_wr_gnt_o <= 1'b0;
      wr_sel_o     <= '0;
    end else begin
      case (wr_st_q)
        W_IDLE: begin
          if (gen_wr_req_i && (occ_q < CW'(N_BUF)) && !buf_wr_lock_i[wr_ptr_q]) begin
            wr_st_q      <= W_BUSY;
            gen_wr_gnt_o <= 1'b1;
            wr_sel_o     <= onehot(wr_ptr_q);
          end
        end
        W_BUSY: begin
          if (gen_wr_stop_i) begin
            wr_st_q      <= W_IDLE;
            gen_wr_gnt_o <= 1'b0;
            wr_sel_o     <= '0;
            wr_ptr_q     <= ring_idx(int'(wr_ptr_q) + 1);
          end
        end
        default: wr_st_q <= W_IDLE;
      endcase
    end
  end

  // Read FSM: one-cycle start pulse on grant, release on read-complete.
  always_ff @(posedge clk) begin
    if (rst || !controller_work_st_i) begin
      rd_st_q    <= R_IDLE;
      tx_gnt_o   <= 1'b0;
      tx_start_o <= 1'b0;
      tx_retx_o  <= 1'b0;
      rd_sel_o   <= '0;
      tx_idx_o   <= '0;
    end else begin
      case (rd_st_q)
        R_IDLE: begin
          if (rd_go) begin
            rd_st_q    <= R_BUSY;
            tx_gnt_o   <= 1'b1;
            tx_start_o <= 1'b1;
            tx_retx_o  <= retx_hit;
            rd_sel_o   <= onehot(rd_idx_d);
            tx_idx_o   <= rd_idx_d;
          end
        end
        R_BUSY: begin
          tx_start_o <= 1'b0;
          if (tx_stop_i) begin
            rd_st_q   <= R_IDLE;
            tx_gnt_o  <= 1'b0;
            tx_retx_o <= 1'b0;
            rd_sel_o  <= '0;
            tx_idx_o  <= '0;
          end
        end
        default: rd_st_q <= R_IDLE;
      endcase
    end
  end

  // Occupancy and sent counters; a controller drop forgets all send history.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q          <= '0;
      sent_q         <= '0;
      prev_wr_lock_q <= '0;
    end else begin
      prev_wr_lock_q <= buf_wr_lock_i;
      occ_q          <= count_next(occ_q, wr_done, n_fall);
      sent_q         <= controller_work_st_i ? count_next(sent_q, fresh_go, n_fall) : '0;
    end
  end

endmodule

// File: tb/tb_tcp_mem_sched.sv
// Directed bench for tcp_mem_sched (N_BUF=2) with a queue-based reference
// model compared every cycle and literal expectations at key points.
module tb_tcp_mem_sched;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] wl = '0, rl = '0, sl = '0;
  logic         work = 1'b1, wreq = 1'b0, wstop = 1'b0, treq = 1'b0, tstop = 1'b0;
  logic         wgnt, tgnt, tstart, tretx;
  logic [N-1:0] wsel, rsel;
  logic [0:0]   tidx;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  tcp_mem_sched #(.N_BUF(N)) dut (
    .clk(clk), .rst(rst),
    .buf_wr_lock_i(wl), .buf_rd_lock_i(rl), .buf_seq_lock_i(sl),
    .controller_work_st_i(work),
    .gen_wr_req_i(wreq), .gen_wr_stop_i(wstop), .gen_wr_gnt_o(wgnt), .wr_sel_o(wsel),
    .tx_req_i(treq), .tx_stop_i(tstop), .tx_gnt_o(tgnt), .tx_start_o(tstart),
    .tx_retx_o(tretx), .rd_sel_o(rsel), .tx_idx_o(tidx)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  // Reference model: q holds written-and-unacked buffer indices, oldest first;
  // the first m_sent entries have been sent at least once.
  int           q[$];
  int           m_sent = 0, m_wrp = 0, m_widx = 0, m_ridx = 0;
  bit           m_wbusy = 0, m_rbusy = 0, m_rstart = 0, m_retx = 0;
  logic [N-1:0] m_prev = '0;

  task automatic model_step();
    int nf, cand;
    bit is_retx, wdone;
    if (rst) begin
      q.delete();
      m_sent = 0; m_wrp = 0; m_widx = 0; m_ridx = 0;
      m_wbusy = 0; m_rbusy = 0; m_rstart = 0; m_retx = 0;
      m_prev = '0;
      return;
    end
    nf = 0;
    for (int i = 0; i < N; i++) if (m_prev[i] && !wl[i]) nf++;
    m_prev = wl;
    cand = -1;
    is_retx = 0;
    if (work && treq && !m_rbusy) begin
      for (int k = 0; k < m_sent; k++)
        if (cand < 0 && wl[q[k]] && !rl[q[k]] && sl[q[k]]) begin
          cand = q[k];
          is_retx = 1;
        end
      if (cand < 0 && m_sent < q.size() && wl[q[m_sent]]) cand = q[m_sent];
    end
    wdone = 0;
    if (!m_wbusy) begin
      if (wreq && q.size() < N && !wl[m_wrp]) begin
        m_wbusy = 1;
        m_widx = m_wrp;
      end
    end else if (wstop) begin
      m_wbusy = 0;
      wdone = 1;
    end
    if (!work) begin
      m_rbusy = 0; m_rstart = 0; m_retx = 0;
    end else if (m_rbusy) begin
      m_rstart = 0;
      if (tstop) begin
        m_rbusy = 0;
        m_retx = 0;
      end
    end else if (cand >= 0) begin
      m_rbusy = 1; m_rstart = 1; m_retx = is_retx; m_ridx = cand;
      if (!is_retx) m_sent++;
    end
    for (int i = 0; i < nf && q.size() > 0; i++) void'(q.pop_front());
    if (wdone) begin
      q.push_back(m_wrp);
      m_wrp = (m_wrp + 1) % N;
    end
    m_sent = work ? ((m_sent - nf < 0) ? 0 : m_sent - nf) : 0;
  endtask

  // Per-cycle compare of DUT against the model, 1 time unit after the edge.
  initial forever begin
    @(posedge clk);
    model_step();
    #1;
    chk("m_wr_gnt", wgnt, m_wbusy);
    chk("m_wr_sel", wsel, m_wbusy ? (1 << m_widx) : 0);
    chk("m_tx_gnt", tgnt, m_rbusy);
    chk("m_tx_start", tstart, m_rstart);
    chk("m_tx_retx", tretx, m_retx);
    chk("m_rd_sel", rsel, m_rbusy ? (1 << m_ridx) : 0);
    chk("m_tx_idx", tidx, m_rbusy ? m_ridx : 0);
    chk("m_occ", dut.occ_q, q.size());
    chk("m_sent", dut.sent_q, m_sent);
    chk("m_wr_ptr", dut.wr_ptr_q, m_wrp);
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_wgnt", wgnt, 0); chk("rst_rsel", rsel, 0); chk("rst_occ", dut.occ_q, 0);
    rst = 1'b0;
    // two fills: buffer 0 then buffer 1
    @(negedge clk); wreq = 1;
    @(negedge clk); chk("w0_sel", wsel, 2'b01); wreq = 0; wstop = 1;
    @(negedge clk); wstop = 0; wl = 2'b01; wreq = 1;
    @(negedge clk); chk("w1_sel", wsel, 2'b10); wreq = 0; wstop = 1;
    @(negedge clk); wstop = 0; wl = 2'b11; wreq = 1; chk("occ_full", dut.occ_q, 2);
    @(negedge clk); wstop = 1;
    @(negedge clk); chk("full_stall", wgnt, 0); chk("idle_stop_ptr", dut.wr_ptr_q, 0);
    wstop = 0; wreq = 0; treq = 1;
    // fresh reads in write order
    @(negedge clk); chk("r0_sel", rsel, 2'b01); chk("r0_start", tstart, 1);
    chk("r0_retx", tretx, 0); chk("r0_sent", dut.sent_q, 1); treq = 0;
    @(negedge clk); chk("r0_start_pulse", tstart, 0); tstop = 1;
    @(negedge clk); tstop = 0; rl = 2'b01; sl = 2'b01; treq = 1;
    @(negedge clk); chk("r1_sel", rsel, 2'b10); treq = 0; tstop = 1;
    @(negedge clk); tstop = 0; rl = 2'b11; sl = 2'b11;
    // buffer 0 timer expiry -> retransmission
    @(negedge clk); rl = 2'b10; treq = 1;
    @(negedge clk); chk("retx_sel", rsel, 2'b01); chk("retx_flag", tretx, 1);
    chk("retx_sent", dut.sent_q, 2); treq = 0; tstop = 1;
    @(negedge clk); tstop = 0; rl = 2'b11;
    // cumulative ACK frees both
    @(negedge clk); wl = 2'b00; rl = 2'b00; sl = 2'b00;
    @(negedge clk); chk("ack_occ", dut.occ_q, 0); chk("ack_sent", dut.sent_q, 0); wreq = 1;
    @(negedge clk); chk("w2_sel", wsel, 2'b01); wreq = 0; wstop = 1;
    @(negedge clk); wstop = 0; wl = 2'b01; treq = 1;
    @(negedge clk); chk("r2_sel", rsel, 2'b01); treq = 0; tstop = 1;
    @(negedge clk); tstop = 0; rl = 2'b01; sl = 2'b01; wreq = 1;
    // write stop and ACK fall in the same cycle
    @(negedge clk); chk("w3_sel", wsel, 2'b10); wreq = 0; wstop = 1; wl = 2'b00; rl = 2'b00; sl = 2'b00;
    @(negedge clk); wstop = 0; wl = 2'b10; treq = 1;
    chk("wf_occ", dut.occ_q, 1); chk("wf_sent", dut.sent_q, 0); chk("wf_ptr", dut.wr_ptr_q, 0);
    @(negedge clk); chk("r3_sel", rsel, 2'b10); chk("r3_idx", tidx, 1); chk("r3_retx", tretx, 0);
    treq = 0; rl = 2'b10; sl = 2'b10;
    // controller leaves working state mid-read
    @(negedge clk); work = 0; rl = 2'b00;
    @(negedge clk); chk("wk_rsel", rsel, 0); chk("wk_gnt", tgnt, 0); chk("wk_sent", dut.sent_q, 0);
    work = 1; treq = 1;
    @(negedge clk); chk("re_sel", rsel, 2'b10); chk("re_retx", tretx, 0);
    chk("re_sent", dut.sent_q, 1); treq = 0; wreq = 1;
    // reset while both FSMs are busy
    @(negedge clk); chk("both_wgnt", wgnt, 1); chk("both_rgnt", tgnt, 1); rst = 1; wreq = 0;
    @(negedge clk); chk("rst2_wgnt", wgnt, 0); chk("rst2_wsel", wsel, 0);
    chk("rst2_rsel", rsel, 0); chk("rst2_tgnt", tgnt, 0);
    chk("rst2_occ", dut.occ_q, 0); chk("rst2_ptr", dut.wr_ptr_q, 0);
    rst = 0; wl = '0; rl = '0; sl = '0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
